// File: rtl/gost_subst_rot_stage.sv
// gost_subst_rot_stage: GOST 28147-89 round tail (S-box, rotate, xor, swap)
// as a two-stage valid/ready pipeline with a runtime-writable S-box table.
module gost_subst_rot_stage #(
   parameter int unsigned ROT = 11
) (
   input  logic        iclk,
   input  logic        irst,
   input  logic        ivalid,
   output logic        oready,
   input  logic [31:0] isum,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic        ovalid,
   input  logic        iready,
   output logic [31:0] on1,
   output logic [31:0] on2,
   input  logic        itbl_we,
   input  logic [6:0]  itbl_addr,
   input  logic [3:0]  itbl_data
);

   localparam int unsigned RSH = (32 - ROT) % 32;

   logic [3:0]  tbl_q [8][16];
   logic        s1_valid_q;
   logic [31:0] sub_q;
   logic [31:0] n1_q;
   logic [31:0] n2_q;
   logic        ovalid_q;
   logic [31:0] on1_q;
   logic [31:0] on2_q;

   logic [31:0] sub_d;
   logic [31:0] rol_w;
   logic        adv2;
   logic        take;
   logic        mv;

   assign adv2   = !ovalid_q || iready;
   assign oready = !s1_valid_q || adv2;
   assign take   = ivalid && oready;
   assign mv     = s1_valid_q && adv2;

   assign ovalid = ovalid_q;
   assign on1    = on1_q;
   assign on2    = on2_q;

   // Lookup reads the table before any same-edge write lands.
   always_comb begin
      sub_d = '0;
      for (int b = 0; b < 8; b++) begin
         sub_d[4*b +: 4] = tbl_q[b][isum[4*b +: 4]];
      end
   end

   // RSH folds to 0 when ROT is 0, so both terms collapse to sub_q.
   assign rol_w = (sub_q << ROT) | (sub_q >> RSH);

   always_ff @(posedge iclk) begin
      if (irst) begin
         for (int b = 0; b < 8; b++) begin
            for (int e = 0; e < 16; e++) begin
               tbl_q[b][e] <= 4'(e);
            end
         end
      end else if (itbl_we) begin
         tbl_q[itbl_addr[6:4]][itbl_addr[3:0]] <= itbl_data;
      end
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         s1_valid_q <= 1'b0;
         sub_q      <= '0;
         n1_q       <= '0;
         n2_q       <= '0;
      end else if (take) begin
         s1_valid_q <= 1'b1;
         sub_q      <= sub_d;
         n1_q       <= in1;
         n2_q       <= in2;
      end else if (mv) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         ovalid_q <= 1'b0;
         on1_q    <= '0;
         on2_q    <= '0;
      end else if (mv) begin
         ovalid_q <= 1'b1;
         on1_q    <= rol_w ^ n2_q;
         on2_q    <= n1_q;
      end else if (iready) begin
         ovalid_q <= 1'b0;
      end
   end

endmodule

// File: doc/gost_subst_rot_stage.md
Name: gost_subst_rot_stage

Overview:
- Downstream consumer of the round's 32-bit prefix adder sum (N1 + K mod 2^32).
- Completes the GOST 28147-89 round function: substitutes the sum through eight 4-bit S-boxes, rotates left by 11 and XORs with N2.
- Also produces the swapped half-block. Output: new N1 = f(sum) ^ N2, new N2 = N1.
- Two-stage pipeline with valid/ready handshake on both sides and a runtime-writable S-box table.

Parameters:
- ROT, 11, left-rotate amount applied after substitution; legal range 0..31.

Ports:
- iclk  in  1  clock; all state updates on the rising edge.
- irst  in  1  synchronous, active-high reset.
- ivalid  in  1  upstream presents isum/in1/in2.
- oready  out  1  stage can accept an input this cycle.
- isum  in  32  adder result N1+K.
- in1  in  32  current N1 half.
- in2  in  32  current N2 half.
- ovalid  out  1  on1/on2 hold a result.
- iready  in  1  downstream accepts the result.
- on1  out  32  rol(S(isum), ROT) ^ in2.
- on2  out  32  in1 passed through.
- itbl_we  in  1  S-box table write enable.
- itbl_addr  in  7  [6:4] box index b, [3:0] entry index e.
- itbl_data  in  4  new value for table[b][e].

Behaviour:
- Reset (irst=1 at edge):
  - Both stage valid flags and ovalid go to 0.
  - on1 and on2 go to 0.
  - All 128 table entries go to identity: table[b][e] = e.
  - The reset overrides any same-cycle handshake or write.
  - Reset mid-operation discards in-flight data with no output.
- Substitution:
  - Box b maps nibble isum[4b+3:4b] to result nibble [4b+3:4b], for b = 0..7.
  - The lookup happens on capture into stage 1.
- Stage 1 registers:
  - s1_valid, sub[31:0] = S(isum), n1_q, n2_q.
- Stage 2 registers:
  - ovalid.
  - on1 = rol32(sub, ROT) ^ n2_q.
  - on2 = n1_q.
- Handshake:
  - adv2 = !ovalid | iready.
  - oready = !s1_valid | adv2. This is combinational; it must not depend on ivalid.
  - An input transfers when ivalid & oready.
  - Stage 1 → stage 2 moves when s1_valid & adv2.
  - An output transfer completes when ovalid & iready.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to ovalid=1.
  - Full throughput: one result per cycle with iready held at 1.
- Stall behaviour:
  - With iready=0 and ovalid=1, on1/on2/ovalid hold stable.
  - Stage 1 fills, then oready drops to 0.
  - No data is lost or duplicated.
  - When iready returns, oready rises in the same cycle.
- Clearing:
  - A stage with no incoming data and an advancing output clears its valid flag.
  - Data registers may hold stale values while valid=0.
- Table writes:
  - Writes are accepted every cycle regardless of pipeline state.
  - A write takes effect at the edge.
  - A capture into stage 1 in the same cycle uses the pre-write contents.
  - Data already in stage 1 or 2 is unaffected by writes.
- Simultaneous events: input transfer, stage advance, output transfer and table write may all occur in one cycle; each is applied independently per the rules above.
- Width: all arithmetic is 32-bit with no carries. Rotation wraps bit 31 to bit ROT-1.

Test Plan:
1. Reset, identity table, ROT=11, iready=1; isum=0x00000001, in1=0x12345678, in2=0 → after 2 cycles ovalid=1, on1=0x00000800, on2=0x12345678.
2. Identity table; isum=0x80000000, in2=0xFFFFFFFF → on1=0xFFFFFBFF (rotate wrap: bit 31 → bit 10).
3. Write all 128 entries with table[b][e]=~e; then isum=0, in2=0x0F0F0F0F → on1=0xF0F0F0F0. Write table[0][0]=0xA in the same cycle as an input isum=0 → that result uses the old 0xF; the next isum=0 gives sub=0xFFFFFFFA, on1=rol(0xFFFFFFFA,11) ^ in2.
4. Stream 4 inputs back-to-back with iready=0 → oready=1,1,0,0 and ovalid holds the first result. Raise iready → results emerge in order, one per cycle, none lost or duplicated.
5. Assert irst while 2 items are in flight → next cycle ovalid=0, on1=on2=0, the table is back to identity and oready=1.
6. Random stream with random ivalid/iready, compared against a reference model → all outputs match, in order.
